branch_predict_unit: RTL and testbench

Parametrised successor to the execute-stage branch comparator. Resolves all six RV32I conditional branches directly from operand values, with no dependence on ALU zero/LSB. Holds a direct-mapped branch history table (BHT) of saturating counters. Supplies a taken/not-taken prediction to fetch, and flags mispredictions to the hazard unit.

---
 rtl/branch_predict_unit.sv | 117 +++++++++++
 tb/tb_branch_predict_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolver with a direct-mapped table of saturating counters
// for fetch-time prediction. Define BRANCH_STATS_EN to add update/mispredict counters.
module branch_predict_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] pc_if,
   output logic                  predict_taken,
   input  logic                  Branch,
   input  logic [2:0]            branchType,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic [ADDR_WIDTH-1:0] pc_ex,
   input  logic                  predicted_taken_ex,
   input  logic                  stall_ex,
   output logic                  branch_taken,
   output logic                  mispredict,
`ifdef BRANCH_STATS_EN
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispredicts,
`endif
   output logic                  illegal_branch
);

   localparam int IDX = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   // weakly-not-taken: MSB clear, all lower bits set
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

   logic [IDX-1:0]      lookup_idx;
   logic [IDX-1:0]      update_idx;
   logic [CTR_BITS-1:0] ctr_cur;
   logic [CTR_BITS-1:0] ctr_next;
   logic                type_valid;
   logic                cond_taken;
   logic                eq;
   logic                lt_s;
   logic                lt_u;
   logic                do_update;
   logic                unused_pc_bits;

   assign lookup_idx = pc_if[IDX+1:2];
   assign update_idx = pc_ex[IDX+1:2];

   // lookup reads the registered table only, so a same-cycle update is not bypassed
   assign predict_taken = bht[lookup_idx][CTR_BITS-1];

   assign eq   = (rs1_data == rs2_data);
   assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
   assign lt_u = (rs1_data < rs2_data);

   always_comb begin
      cond_taken = 1'b0;
      type_valid = 1'b1;
      case (branchType)
         F3_BEQ:  cond_taken = eq;
         F3_BNE:  cond_taken = !eq;
         F3_BLT:  cond_taken = lt_s;
         F3_BGE:  cond_taken = !lt_s;
         F3_BLTU: cond_taken = lt_u;
         F3_BGEU: cond_taken = !lt_u;
         default: type_valid = 1'b0;
      endcase
   end

   assign branch_taken   = Branch && type_valid && cond_taken;
   assign illegal_branch = Branch && !type_valid;
   assign mispredict     = Branch && type_valid && (cond_taken != predicted_taken_ex);
   assign do_update      = Branch && type_valid && !stall_ex;

   always_comb begin
      ctr_cur  = bht[update_idx];
      ctr_next = ctr_cur;
      if (cond_taken) begin
         if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
      end else begin
         if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
      end else if (do_update) begin
         bht[update_idx] <= ctr_next;
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (do_update) begin
         stat_branches <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

   assign unused_pc_bits = ^{pc_if[ADDR_WIDTH-1:IDX+2], pc_if[1:0],
                             pc_ex[ADDR_WIDTH-1:IDX+2], pc_ex[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit at default parameters; covers the
// stats counters too when built with BRANCH_STATS_EN.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_if;
   logic        predict_taken;
   logic        Branch;
   logic [2:0]  branchType;
   logic [31:0] rs1_data, rs2_data, pc_ex;
   logic        predicted_taken_ex, stall_ex;
   logic        branch_taken, mispredict, illegal_branch;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   branch_predict_unit dut (
      .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .predict_taken(predict_taken),
      .Branch(Branch), .branchType(branchType), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .pc_ex(pc_ex), .predicted_taken_ex(predicted_taken_ex), .stall_ex(stall_ex),
      .branch_taken(branch_taken), .mispredict(mispredict),
`ifdef BRANCH_STATS_EN
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
      .illegal_branch(illegal_branch)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // expected {predict_taken, branch_taken, mispredict, illegal_branch}
   logic [3:0] sb [$];
   logic [1:0] mdl [64];
   logic       pend_upd;
   logic       pend_taken;
   logic [5:0] pend_idx;
   int         exp_stat_br = 0;
   int         exp_stat_mis = 0;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mdl[i] = 2'b01;
      pend_upd = 1'b0;
      exp_stat_br = 0;
      exp_stat_mis = 0;
   endtask

   task automatic drive_br(input logic br, input logic [2:0] typ, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_tk, input logic pred_ex,
                           input logic stall, input logic [31:0] pcx, input logic [31:0] pci);
      logic valid, tk, mis, ill;
      Branch = br; branchType = typ; rs1_data = a; rs2_data = b;
      predicted_taken_ex = pred_ex; stall_ex = stall; pc_ex = pcx; pc_if = pci;
      valid = (typ[2:1] != 2'b01);
      tk    = br && valid && exp_tk;
      ill   = br && !valid;
      mis   = br && valid && (exp_tk != pred_ex);
      sb.push_back({mdl[pci[7:2]][1], tk, mis, ill});
      pend_upd   = br && valid && !stall;
      pend_taken = exp_tk;
      pend_idx   = pcx[7:2];
      if (pend_upd) begin
         exp_stat_br++;
         if (mis) exp_stat_mis++;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (pend_upd) begin
         if (pend_taken && mdl[pend_idx] != 2'b11) mdl[pend_idx] = mdl[pend_idx] + 2'b01;
         if (!pend_taken && mdl[pend_idx] != 2'b00) mdl[pend_idx] = mdl[pend_idx] - 2'b01;
      end
      pend_upd = 1'b0;
      #1;
   endtask

   task automatic idle();
      drive_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      void'(sb.pop_back());
   endtask

   task automatic test_reset();
      logic [3:0] exp, obs;
      for (int i = 0; i <= 64; i++) begin
         drive_br(1'b0, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 32'd0,
                  (i == 64) ? 32'h100 : 32'(i * 4));
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL reset idx %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

   typedef struct { logic [2:0] typ; logic [31:0] a; logic [31:0] b; logic tk; } cmp_t;

   task automatic test_compare();
      cmp_t tbl [14];
      logic [3:0] exp, obs;
      tbl = '{'{3'b100, 32'hFFFFFFFF, 32'd1, 1'b1}, '{3'b110, 32'hFFFFFFFF, 32'd1, 1'b0},
              '{3'b111, 32'hFFFFFFFF, 32'd1, 1'b1}, '{3'b000, 32'd5, 32'd5, 1'b1},
              '{3'b001, 32'd5, 32'd5, 1'b0},        '{3'b101, 32'hFFFFFFFF, 32'd1, 1'b0},
              '{3'b100, 32'd1, 32'hFFFFFFFF, 1'b0}, '{3'b101, 32'd5, 32'd5, 1'b1},
              '{3'b110, 32'd5, 32'd6, 1'b1},        '{3'b000, 32'd5, 32'd6, 1'b0},
              '{3'b001, 32'd5, 32'd6, 1'b1},        '{3'b111, 32'd0, 32'd0, 1'b1},
              '{3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b1},
              '{3'b110, 32'h80000000, 32'h7FFFFFFF, 1'b0}};
      // stalled, so comparisons leave the table untouched
      for (int i = 0; i < 14; i++) begin
         drive_br(1'b1, tbl[i].typ, tbl[i].a, tbl[i].b, tbl[i].tk, 1'b0, 1'b1, 32'h40, 32'h40);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL compare row %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

   // three taken then one not-taken at 0x40, prediction fed back as predicted_taken_ex
   task automatic test_training();
      logic [3:0] exp, obs;
      logic tk;
      for (int i = 0; i < 5; i++) begin
         tk = (i < 3);
         if (i == 4) idle();
         else drive_br(1'b1, 3'b000, 32'd5, tk ? 32'd5 : 32'd6, tk, mdl[16][1], 1'b0,
                       32'h40, 32'h40);
         if (i == 4) drive_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h40);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL training step %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

   task automatic test_async_reset();
      logic obs;
      drive_br(1'b1, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 32'h40, 32'h40);
      void'(sb.pop_back());
      #2 rst_n = 1'b0;
      #1 obs = predict_taken;
      checks++;
      if (obs !== 1'b0) $display("FAIL async_reset predict: got %b expected 0", obs);
      else passed++;
`ifdef BRANCH_STATS_EN
      checks++;
      if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
         $display("FAIL async_reset stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
      else passed++;
`endif
      model_reset();
      @(negedge clk);
      Branch = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // update 0x40 while fetching 0x40, then read back via the alias 0x140
   task automatic test_collision();
      logic [3:0] exp, obs;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drive_br(1'b1, 3'b000, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 32'h40, 32'h40);
         else drive_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0,
                       (i == 1) ? 32'h40 : 32'h140);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL collision step %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

   task automatic test_illegal();
      logic [3:0] exp, obs;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) drive_br(1'b1, (i == 0) ? 3'b010 : 3'b011, 32'd1, 32'd2, 1'b0, 1'b1,
                             1'b0, 32'h40, 32'h40);
         else drive_br(1'b0, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 32'h40, 32'h40);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL illegal/nobranch step %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

   // stalled taken, then decrements past zero, then taken, at fresh index 0x10
   task automatic test_stall_saturate();
      logic [3:0] exp, obs;
      logic [4:0] tk_pat = 5'b10001;
      logic [4:0] st_pat = 5'b00001;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) drive_br(1'b1, 3'b001, 32'd3, tk_pat[i] ? 32'd4 : 32'd3, tk_pat[i],
                             1'b0, st_pat[i], 32'h10, 32'h10);
         else drive_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h10);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL stall_saturate step %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

   // taken updates every cycle at 0x0C, fetch reading the same counter
   task automatic test_back_to_back();
      logic [3:0] exp, obs;
      for (int i = 0; i < 5; i++) begin
         drive_br(1'b1, 3'b111, 32'd9, 32'd2, 1'b1, mdl[3][1], 1'b0, 32'h0C, 32'h10C);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
   endtask

`ifdef BRANCH_STATS_EN
   task automatic test_stats();
      logic [3:0] exp, obs;
      logic [11:0] mis_pat = 12'b0000_1001_0001;
      for (int i = 0; i < 12; i++) begin
         // i == 10: stalled, i == 11: reserved type -- neither counts
         if (i == 11) drive_br(1'b1, 3'b011, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h200);
         else drive_br(1'b1, 3'b000, 32'd1, 32'd1, 1'b1, !mis_pat[i], (i == 10), 32'h200, 32'h200);
         @(negedge clk);
         exp = sb.pop_front();
         obs = {predict_taken, branch_taken, mispredict, illegal_branch};
         checks++;
         if (obs !== exp) $display("FAIL stats step %0d: got %b expected %b", i, obs, exp);
         else passed++;
         advance();
      end
      idle();
      @(negedge clk);
      checks++;
      if (exp_stat_br != 10 || exp_stat_mis != 3 || stat_branches !== 32'd10 || stat_mispredicts !== 32'd3)
         $display("FAIL stats counts: got %0d/%0d expected 10/3", stat_branches, stat_mispredicts);
      else passed++;
      advance();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      model_reset();
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_compare();
      test_training();
      test_async_reset();
      test_collision();
      test_illegal();
      test_stall_saturate();
      test_back_to_back();
`ifdef BRANCH_STATS_EN
      test_stats();
      test_async_reset();
`endif
      checks++;
      if (sb.size() != 0) $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
